uart_transmitter: RTL and testbench

Serializes parallel bytes into an asynchronous UART frame: a start bit, DATA_BITS data bits sent LSB first, an optional even-parity bit, and STOP_BITS stop bits. It is the transmit counterpart of the receive chain (start-bit detector plus bit sampler) and shares the same 16x oversampling `sample_trigger` tick, so every transmitted bit lasts exactly SAMPLES_PER_BIT ticks. Upstream logic loads bytes through a valid/ready handshake; `tx_out` drives the pad.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_bit_timer.sv | 36 +++
 rtl/uart_transmitter.sv | 134 +++++++++++++
 tb/tb_uart_transmitter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive chains.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int SamplesPerBitDefault = 16;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts oversampling ticks and flags the tick that ends the current bit.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = SamplesPerBitDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_trigger,
  output logic bit_end
);

  localparam int CntW = $clog2(SAMPLES_PER_BIT + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(SAMPLES_PER_BIT - 1);

  logic [CntW-1:0] count;

  // Combinational so the state machine advances on the terminal tick's own edge.
  assign bit_end = sample_trigger && !clear && (count == LastCount);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sample_trigger) begin
      if (count == LastCount) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART frame serializer: start, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int SAMPLES_PER_BIT = SamplesPerBitDefault,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_trigger,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IdxW = $clog2(DATA_BITS + 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  uart_tx_state_e       state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IdxW-1:0]      bit_idx;
  logic                 accept;
  logic                 bit_end;

  assign accept = data_valid && data_ready;

  uart_tx_bit_timer #(
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_bit_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (accept),
    .sample_trigger(sample_trigger),
    .bit_end       (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  // Parity is taken from the captured byte because the shift register drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      tx_out     <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            shift_reg  <= data;
            bit_idx    <= '0;
            tx_out     <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx_out <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LastData) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_out  <= parity_bit;
`else
              state   <= STOP;
              tx_out  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          // bit_idx is reused to count stop bits once the data bits are out.
          if (bit_end) begin
            if (bit_idx == LastStop) begin
              state      <= IDLE;
              bit_idx    <= '0;
              data_ready <= 1'b1;
              busy       <= 1'b0;
              tx_done    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tx_out     <= 1'b1;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter; honours UART_TX_PARITY_EN when defined.
module tb_uart_transmitter;

  localparam int DB  = 8;
  localparam int SPB = 16;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          sample_trigger;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic          tx_out;
  logic          busy;
  logic          tx_done;
  logic          trig_en;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(
    .DATA_BITS      (DB),
    .SAMPLES_PER_BIT(SPB),
    .STOP_BITS      (SB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_trigger(sample_trigger),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .tx_out        (tx_out),
    .busy          (busy),
    .tx_done       (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One trigger every fourth clock, changed on the falling edge.
  initial begin
    int phase;
    phase = 0;
    sample_trigger = 1'b0;
    forever begin
      @(negedge clk);
      if (trig_en) begin
        sample_trigger = (phase == 3);
        phase = (phase + 1) % 4;
      end else begin
        sample_trigger = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DB-1:0] d, input bit keep_valid);
    int w;
    w = 0;
    while (data_ready !== 1'b1 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("ready_before_send", data_ready, 1'b1);
    data       = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("accept_line", tx_out, 1'b0);
    checkOutput("accept_ready", data_ready, 1'b0);
    checkOutput("accept_busy", busy, 1'b1);
    if (!keep_valid) data_valid = 1'b0;
  endtask

  // Expected line level is looked up from a bit list built from the frame rules.
  task automatic monitorFrame(input logic [DB-1:0] d, input int abort_tick,
                              input int inject_tick, input int pause_tick);
    logic exp_q[$];
    int   t, n, budget, frame_ticks;
    bit   done, injected, clr_inject, paused, hold_ok;
    t = 0; n = 0; done = 0; injected = 0; clr_inject = 0; paused = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_q.push_back(d[i]);
    if (Par == 1) exp_q.push_back(^d);
    for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
    frame_ticks = exp_q.size() * SPB;
    budget = frame_ticks * 4 + 1500;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (clr_inject) begin
        data_valid = 1'b0;
        clr_inject = 0;
      end
      if (sample_trigger) t++;
      if (t >= frame_ticks) begin
        checkOutput("done_pulse", tx_done, 1'b1);
        checkOutput("done_line", tx_out, 1'b1);
        checkOutput("done_ready", data_ready, 1'b1);
        checkOutput("done_busy", busy, 1'b0);
        done = 1;
      end else begin
        checkOutput("line", tx_out, exp_q[t / SPB]);
        checkOutput("no_early_done", tx_done, 1'b0);
        checkOutput("busy_in_frame", busy, 1'b1);
        if (t == abort_tick) begin
          #2 rst_n = 1'b0;
          #1;
          checkOutput("abort_line", tx_out, 1'b1);
          checkOutput("abort_ready", data_ready, 1'b1);
          checkOutput("abort_busy", busy, 1'b0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          hold_ok = 1;
          repeat (300) begin
            @(posedge clk);
            #1;
            if (tx_done !== 1'b0 || tx_out !== 1'b1) hold_ok = 0;
          end
          checkOutput("abort_no_done", hold_ok, 1'b1);
          done = 1;
        end else if (t == inject_tick && !injected) begin
          data       = 8'h12;
          data_valid = 1'b1;
          injected   = 1;
          clr_inject = 1;
        end else if (t == pause_tick && !paused) begin
          paused  = 1;
          trig_en = 1'b0;
          hold_ok = 1;
          repeat (1000) begin
            @(posedge clk);
            #1;
            if (tx_out !== exp_q[t / SPB] || busy !== 1'b1) hold_ok = 0;
          end
          checkOutput("pause_hold", hold_ok, 1'b1);
          trig_en = 1'b1;
        end
      end
    end
    if (!done) checkOutput("frame_timeout", done, 1'b1);
  endtask

  initial begin
    logic [DB-1:0] r;
    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    trig_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_line", tx_out, 1'b1);
    checkOutput("reset_ready", data_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] frame 0x55");
    applyStimulus(8'h55, 0);
    monitorFrame(8'h55, -1, -1, -1);

    $display("[TB] parity frames 0xA3 and 0xA7");
    applyStimulus(8'hA3, 0);
    monitorFrame(8'hA3, -1, -1, -1);
    applyStimulus(8'hA7, 0);
    monitorFrame(8'hA7, -1, -1, -1);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 1);
    monitorFrame(8'h00, -1, -1, -1);
    data = 8'hFF;
    @(posedge clk);
    #1;
    checkOutput("b2b_start_line", tx_out, 1'b0);
    checkOutput("b2b_start_ready", data_ready, 1'b0);
    checkOutput("b2b_start_busy", busy, 1'b1);
    data_valid = 1'b0;
    monitorFrame(8'hFF, -1, -1, -1);

    $display("[TB] ignored byte mid-frame");
    r = DB'($urandom_range(0, 255));
    applyStimulus(r, 0);
    monitorFrame(r, -1, 70, -1);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h3C, 0);
    monitorFrame(8'h3C, 50, -1, -1);
    applyStimulus(8'h96, 0);
    monitorFrame(8'h96, -1, -1, -1);

    $display("[TB] trigger pause during data");
    r = DB'($urandom_range(0, 255));
    applyStimulus(r, 0);
    monitorFrame(r, -1, -1, 40);

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      r = DB'($urandom_range(0, 255));
      applyStimulus(r, 0);
      monitorFrame(r, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
